instr_encoder: RTL and testbench

Encodes operation requests (add, sub, and, or, ld, sd, beq) into 32-bit RV64I instruction words. Encoded words are buffered in a small FIFO and written to the instruction memory write port at sequential word addresses. The block loads self-test programs for the mini CPU and produces the words the control decoder consumes. It also gives a golden model for decoder verification.

---
 rtl/instr_encoder.sv | 112 +++++++++++
 tb/tb_instr_encoder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// RV64I request encoder for add/sub/and/or/ld/sd/beq.
// Encoded words queue in a FIFO and drain to sequential addresses.
module instr_encoder #(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [12:0]       imm,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [15:0]       words_written,
  output logic              err
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] BASE =
    ADDR_W'(BASE_ADDR);

  logic [31:0] mem [DEPTH];
  logic [PW:0] head;
  logic [PW:0] tail;
  logic [31:0] word;
  logic [31:0] last;
  logic        legal;
  logic        full;
  logic        empty;
  logic        acc;
  logic        push;
  logic        pop;
  logic        unused;

  // beq drops imm[0]: branch targets are 2-byte aligned
  assign unused = imm[0];

  always_comb begin
    word  = '0;
    legal = 1'b1;
    unique case (op)
      3'd0: word = {7'b0000000, rs2, rs1,
                    3'b000, rd, 7'b0110011};
      3'd1: word = {7'b0100000, rs2, rs1,
                    3'b000, rd, 7'b0110011};
      3'd2: word = {7'b0000000, rs2, rs1,
                    3'b111, rd, 7'b0110011};
      3'd3: word = {7'b0000000, rs2, rs1,
                    3'b110, rd, 7'b0110011};
      3'd4: word = {imm[11:0], rs1,
                    3'b011, rd, 7'b0000011};
      3'd5: word = {imm[11:5], rs2, rs1,
                    3'b011, imm[4:0], 7'b0100011};
      3'd6: word = {imm[12], imm[10:5], rs2, rs1,
                    3'b000, imm[4:1], imm[11],
                    7'b1100011};
      default: legal = 1'b0;
    endcase
  end

  assign empty = (head == tail);
  assign full  = (head[PW] != tail[PW]) &&
                 (head[PW-1:0] == tail[PW-1:0]);

  assign in_ready = !full;
  assign acc      = in_valid && in_ready;
  assign push     = acc && legal;
  assign wr_en    = !empty;
  assign pop      = wr_en && wr_ready;

  // hold the last drained word while the FIFO is empty
  assign wr_data = empty ? last
                         : mem[head[PW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[tail[PW-1:0]] <= word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head          <= '0;
      tail          <= '0;
      last          <= '0;
      wr_addr       <= BASE;
      words_written <= '0;
      err           <= 1'b0;
    end else begin
      if (push) begin
        tail <= tail + (PW+1)'(1);
      end
      if (pop) begin
        head          <= head + (PW+1)'(1);
        last          <= mem[head[PW-1:0]];
        wr_addr       <= wr_addr + ADDR_W'(4);
        words_written <= words_written + 16'd1;
      end
      if (acc && !legal) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed steps plus random traffic
// checked against a queue-based reference model.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = '0;
  logic [4:0]  rd = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic [12:0] imm = '0;
  logic        wr_en;
  logic        wr_ready = 1'b0;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic [15:0] words_written;
  logic        err;

  logic        rst2 = 1'b1;
  logic        in_valid2 = 1'b0;
  logic        in_ready2;
  logic        wr_en2;
  logic        wr_ready2 = 1'b0;
  logic [3:0]  wr_addr2;
  logic [31:0] wr_data2;
  logic [15:0] words_written2;
  logic        err2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm(imm),
    .wr_en(wr_en), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .words_written(words_written), .err(err)
  );

  instr_encoder #(
    .DEPTH(4), .ADDR_W(4), .BASE_ADDR(12)
  ) dut2 (
    .clk(clk), .rst(rst2),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .op(op), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm(imm),
    .wr_en(wr_en2), .wr_ready(wr_ready2),
    .wr_addr(wr_addr2), .wr_data(wr_data2),
    .words_written(words_written2), .err(err2)
  );

  typedef struct {
    logic [31:0] w;
    logic [31:0] lit;
    bit          has;
  } ent_t;

  ent_t        q[$];
  logic [9:0]  m_addr;
  logic [15:0] m_cnt;
  logic        m_err;
  logic [31:0] m_last;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc(
    input logic [2:0] o, input logic [4:0] d,
    input logic [4:0] s1, input logic [4:0] s2,
    input logic [12:0] im);
    logic [31:0] rr;
    rr = (32'(s2) << 20) | (32'(s1) << 15) |
         (32'(d) << 7);
    case (o)
      3'd0: return 32'h33 | rr;
      3'd1: return 32'h33 | rr | (32'h20 << 25);
      3'd2: return 32'h33 | rr | (32'd7 << 12);
      3'd3: return 32'h33 | rr | (32'd6 << 12);
      3'd4: return 32'h03 | (32'd3 << 12) |
                   (32'(d) << 7) | (32'(s1) << 15) |
                   (32'(im[11:0]) << 20);
      3'd5: return 32'h23 | (32'd3 << 12) |
                   (32'(s1) << 15) | (32'(s2) << 20) |
                   (32'(im[4:0]) << 7) |
                   (32'(im[11:5]) << 25);
      3'd6: return 32'h63 |
                   (32'(s1) << 15) | (32'(s2) << 20) |
                   (32'(im[4:1]) << 8) |
                   (32'(im[11]) << 7) |
                   (32'(im[10:5]) << 25) |
                   (32'(im[12]) << 31);
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    q.delete();
    m_addr = 10'h0;
    m_cnt  = 16'h0;
    m_err  = 1'b0;
    m_last = 32'h0;
  endtask

  // one clock: drive, check pre-edge outputs, advance the model
  task automatic cycle(
    output bit acc,
    input bit v, input logic [2:0] o,
    input logic [4:0] d, input logic [4:0] s1,
    input logic [4:0] s2, input logic [12:0] im,
    input bit wr,
    input logic [31:0] lit = 32'h0,
    input bit has = 1'b0);
    ent_t e;
    @(negedge clk);
    in_valid = v; op = o; rd = d;
    rs1 = s1; rs2 = s2; imm = im;
    wr_ready = wr;
    #1;
    chk("wr_en", 32'(wr_en), 32'(q.size() != 0));
    chk("in_ready", 32'(in_ready),
        32'(q.size() < 4));
    chk("wr_addr", 32'(wr_addr), 32'(m_addr));
    chk("words_written", 32'(words_written),
        32'(m_cnt));
    chk("err", 32'(err), 32'(m_err));
    chk("wr_data", wr_data,
        q.size() != 0 ? q[0].w : m_last);
    if (q.size() != 0 && q[0].has)
      chk("wr_data_literal", wr_data, q[0].lit);
    acc = v && (q.size() < 4);
    if (q.size() != 0 && wr) begin
      e = q.pop_front();
      m_last = e.w;
      m_addr = m_addr + 10'd4;
      m_cnt  = m_cnt + 16'd1;
    end
    if (acc) begin
      if (o == 3'd7) m_err = 1'b1;
      else begin
        e.w = enc(o, d, s1, s2, im);
        e.lit = lit;
        e.has = has;
        q.push_back(e);
      end
    end
    @(posedge clk);
  endtask

  // reset with a live handshake that must be ignored
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1;
    op = 3'd0; wr_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    model_reset();
  endtask

  bit a;

  initial begin
    model_reset();
    do_reset();
    cycle(a, 0, 0, 0, 0, 0, 0, 1);
    chk("reset_wr_data", wr_data, 32'h0);

    cycle(a, 1, 0, 3, 1, 2, 0, 1,
          32'h002081B3, 1);
    cycle(a, 0, 0, 0, 0, 0, 0, 1);
    cycle(a, 0, 0, 0, 0, 0, 0, 1);
    chk("first_count", 32'(words_written), 32'd1);

    cycle(a, 1, 1, 5, 6, 7, 0, 1,
          32'h407302B3, 1);
    cycle(a, 1, 4, 4, 2, 0, 13'd8, 1,
          32'h00813203, 1);
    cycle(a, 1, 5, 0, 2, 5, 13'd16, 1,
          32'h00513823, 1);
    cycle(a, 1, 6, 0, 1, 2, 13'h1FFC, 1,
          32'hFE208EE3, 1);
    for (int i = 0; i < 3; i++)
      cycle(a, 0, 0, 0, 0, 0, 0, 1);

    for (int i = 0; i < 4; i++)
      cycle(a, 1, 3'(i), 5'(i + 1), 5'(i + 2),
            5'(i + 3), 13'(4 * i), 0);
    a = 0;
    for (int k = 0; k < 10 && !a; k++)
      cycle(a, 1, 2, 9, 10, 11, 0, k >= 3);
    chk("fifth_accepted", 32'(a), 32'd1);
    for (int i = 0; i < 7; i++)
      cycle(a, 0, 0, 0, 0, 0, 0, 1);

    cycle(a, 1, 0, 1, 2, 3, 0, 1);
    cycle(a, 1, 7, 1, 2, 3, 0, 1);
    cycle(a, 1, 0, 4, 5, 6, 0, 1);
    for (int i = 0; i < 3; i++)
      cycle(a, 0, 0, 0, 0, 0, 0, 1);
    chk("err_sticky", 32'(err), 32'd1);

    for (int i = 0; i < 3; i++)
      cycle(a, 1, 0, 5'(i), 1, 2, 0, 0);
    do_reset();
    cycle(a, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);

    for (int i = 0; i < 400; i++)
      cycle(a, $urandom_range(0, 3) != 0,
            3'($urandom_range(0, 7)),
            5'($urandom), 5'($urandom),
            5'($urandom), 13'($urandom),
            $urandom_range(0, 2) != 0);
    for (int i = 0; i < 6; i++)
      cycle(a, 0, 0, 0, 0, 0, 0, 1);

    @(negedge clk);
    rst2 = 1'b1;
    @(negedge clk);
    rst2 = 1'b0; in_valid2 = 1'b1;
    wr_ready2 = 1'b1; op = 3'd0;
    rd = 5'd1; rs1 = 5'd2; rs2 = 5'd3;
    #1;
    chk("w2_idle_en", 32'(wr_en2), 32'd0);
    chk("w2_base", 32'(wr_addr2), 32'hC);
    @(negedge clk);
    #1;
    chk("w2_en0", 32'(wr_en2), 32'd1);
    chk("w2_addr0", 32'(wr_addr2), 32'hC);
    chk("w2_data0", wr_data2, 32'h003100B3);
    @(negedge clk);
    in_valid2 = 1'b0;
    #1;
    chk("w2_en1", 32'(wr_en2), 32'd1);
    chk("w2_addr1", 32'(wr_addr2), 32'h0);
    @(negedge clk);
    #1;
    chk("w2_en2", 32'(wr_en2), 32'd0);
    chk("w2_addr2", 32'(wr_addr2), 32'h4);
    chk("w2_cnt", 32'(words_written2), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
